// File: rtl/fighter_sprite_addr.sv
// Fighter sprite ROM address generator and animation sequencer.
// Maps the scan position to a mirrored or plain sprite address and steps through an animation strip.
module fighter_sprite_addr #(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 14,
  localparam int FI_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              anim_en,
  input  logic              anim_loop,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic [FI_W-1:0]   frame_idx,
  output logic              anim_done
);
  localparam int AW1  = ADDR_W + 1;
  localparam int HC_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [10:0]     SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]     SPR_H11   = 11'(SPR_H);
  localparam logic [FI_W-1:0] LAST_FI   = FI_W'(FRAMES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(FRAME_HOLD - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state_q;
  logic [FI_W-1:0]   frame_idx_q;
  logic [HC_W-1:0]   hold_cnt_q;
  logic              anim_done_q;
  logic [9:0]        pos_x_s_q, pos_y_s_q;
  logic              flip_s_q;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              hit_q, in_sprite_q;

  logic [10:0]       lx, ly, col;
  logic              hit;
  logic [AW1-1:0]    addr_full;

  // Bit 10 of the zero-extended difference is the borrow: scan is left of/above the box.
  always_comb begin
    lx  = {1'b0, DrawX} - {1'b0, pos_x_s_q};
    ly  = {1'b0, DrawY} - {1'b0, pos_y_s_q};
    hit = !lx[10] && !ly[10] && (lx < SPR_W11) && (ly < SPR_H11);
    col = flip_s_q ? (SPR_W11 - 11'd1 - lx) : lx;
    addr_full = AW1'(frame_idx_q) * AW1'(SPR_W * SPR_H)
              + AW1'(ly) * AW1'(SPR_W)
              + AW1'(col);
    rom_address_d = hit ? addr_full[ADDR_W-1:0] : '0;
  end

  // Shadow copies only move during blanking so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x_s_q <= '0;
      pos_y_s_q <= '0;
      flip_s_q  <= 1'b0;
    end else if (frame_start) begin
      pos_x_s_q <= pos_x;
      pos_y_s_q <= pos_y;
      flip_s_q  <= flip;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_address_q <= '0;
      hit_q         <= 1'b0;
      in_sprite_q   <= 1'b0;
    end else begin
      rom_address_q <= rom_address_d;
      hit_q         <= hit & blank;
      in_sprite_q   <= hit_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      hold_cnt_q  <= '0;
      anim_done_q <= 1'b0;
    end else if (frame_start) begin
      case (state_q)
        IDLE: begin
          frame_idx_q <= '0;
          hold_cnt_q  <= '0;
          anim_done_q <= 1'b0;
          if (anim_en) state_q <= PLAY;
        end
        PLAY: begin
          if (!anim_en) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            hold_cnt_q  <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_q <= '0;
            if (frame_idx_q < LAST_FI) begin
              frame_idx_q <= frame_idx_q + 1'b1;
            end else if (anim_loop) begin
              frame_idx_q <= '0;
            end else begin
              state_q     <= DONE;
              anim_done_q <= 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        DONE: begin
          frame_idx_q <= LAST_FI;
          if (!anim_en) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            hold_cnt_q  <= '0;
            anim_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          frame_idx_q <= '0;
          hold_cnt_q  <= '0;
          anim_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_address = rom_address_q;
  assign in_sprite   = in_sprite_q;
  assign frame_idx   = frame_idx_q;
  assign anim_done   = anim_done_q;
endmodule

// File: tb/tb_fighter_sprite_addr.sv
// Directed bench for fighter_sprite_addr: address table plus playback/reset sequences.
module tb_fighter_sprite_addr;
  logic        vga_clk = 1'b0;
  logic        Reset, frame_start, anim_en, anim_loop, flip, blank;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic [13:0] rom_address;
  logic        in_sprite, anim_done;
  logic [1:0]  frame_idx;

  int n_vec = 0;
  int n_bad = 0;

  always #5 vga_clk = ~vga_clk;

  fighter_sprite_addr dut (
    .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start), .anim_en(anim_en),
    .anim_loop(anim_loop), .pos_x(pos_x), .pos_y(pos_y), .flip(flip),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .rom_address(rom_address),
    .in_sprite(in_sprite), .frame_idx(frame_idx), .anim_done(anim_done)
  );

  typedef struct {
    logic        latch;
    logic        flp;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        blk;
    logic [13:0] exp_addr;
    logic        exp_in;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    int ef;
    tbl[0]  = '{1'b1, 1'b0, 10'd110, 10'd205, 1'b1, 14'd330,  1'b1};
    tbl[1]  = '{1'b0, 1'b0, 10'd164, 10'd205, 1'b1, 14'd0,    1'b0};
    tbl[2]  = '{1'b0, 1'b0, 10'd99,  10'd205, 1'b1, 14'd0,    1'b0};
    tbl[3]  = '{1'b0, 1'b0, 10'd100, 10'd200, 1'b1, 14'd0,    1'b1};
    tbl[4]  = '{1'b0, 1'b0, 10'd163, 10'd263, 1'b1, 14'd4095, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 10'd163, 10'd264, 1'b1, 14'd0,    1'b0};
    tbl[6]  = '{1'b0, 1'b0, 10'd110, 10'd205, 1'b0, 14'd330,  1'b0};
    tbl[7]  = '{1'b1, 1'b1, 10'd110, 10'd205, 1'b1, 14'd373,  1'b1};
    tbl[8]  = '{1'b0, 1'b0, 10'd110, 10'd205, 1'b1, 14'd373,  1'b1};
    tbl[9]  = '{1'b0, 1'b0, 10'd100, 10'd200, 1'b1, 14'd63,   1'b1};
    tbl[10] = '{1'b1, 1'b0, 10'd100, 10'd200, 1'b1, 14'd0,    1'b1};

    Reset = 1'b1; frame_start = 1'b0; anim_en = 1'b0; anim_loop = 1'b0; flip = 1'b0;
    blank = 1'b0; pos_x = '0; pos_y = '0; DrawX = '0; DrawY = '0;

    // Reset held 3 cycles, then 2 cycles after release
    for (int i = 0; i < 5; i++) begin
      if (i == 3) Reset = 1'b0;
      step();
      check("rst_addr", rom_address, 0);
      check("rst_in",   in_sprite,   0);
      check("rst_fidx", frame_idx,   0);
      check("rst_done", anim_done,   0);
    end

    pos_x = 10'd100; pos_y = 10'd200;
    for (int i = 0; i < 11; i++) begin
      flip = tbl[i].flp;
      if (tbl[i].latch) pulse_fs();
      DrawX = tbl[i].dx; DrawY = tbl[i].dy; blank = tbl[i].blk;
      step();
      check($sformatf("addr[%0d]", i), rom_address, tbl[i].exp_addr);
      step();
      check($sformatf("in_sprite[%0d]", i), in_sprite, tbl[i].exp_in);
    end

    // Non-looping playback: entry pulse, then 24 pulses to DONE
    anim_en = 1'b1; anim_loop = 1'b0;
    pulse_fs();
    check("play_entry_fidx", frame_idx, 0);
    for (int j = 1; j <= 24; j++) begin
      pulse_fs();
      ef = (j / 6 > 3) ? 3 : j / 6;
      check($sformatf("nl_fidx[%0d]", j), frame_idx, ef);
      check($sformatf("nl_done[%0d]", j), anim_done, (j >= 24) ? 1 : 0);
      if (j == 12) begin
        DrawX = 10'd100; DrawY = 10'd200; blank = 1'b1;
        step();
        check("frame2_offset", rom_address, 8192);
      end
    end
    pulse_fs();
    check("done_hold_fidx", frame_idx, 3);
    check("done_hold_done", anim_done, 1);
    anim_en = 1'b0;
    pulse_fs();
    check("done_exit_fidx", frame_idx, 0);
    check("done_exit_done", anim_done, 0);

    // Looping playback: wraps after frame 3, then reset mid-playback at frame 2
    anim_en = 1'b1; anim_loop = 1'b1;
    pulse_fs();
    for (int j = 1; j <= 36; j++) begin
      pulse_fs();
      check($sformatf("lp_fidx[%0d]", j), frame_idx, (j / 6) % 4);
      check($sformatf("lp_done[%0d]", j), anim_done, 0);
    end
    blank = 1'b0;
    step(); step();
    check("blank_in_box", in_sprite, 0);
    check("blank_addr", rom_address, 8192);

    blank = 1'b1;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_fidx", frame_idx, 0);
    check("midrst_done", anim_done, 0);
    check("midrst_in",   in_sprite, 0);
    check("midrst_addr", rom_address, 0);

    anim_en = 1'b0;
    pulse_fs();
    check("restart_idle", frame_idx, 0);
    anim_en = 1'b1;
    pulse_fs();
    check("restart_entry", frame_idx, 0);
    for (int j = 1; j <= 6; j++) begin
      pulse_fs();
      check($sformatf("restart_fidx[%0d]", j), frame_idx, j / 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
